// File: rtl/hazard_detect_unit.sv
// hazard_detect_unit: issue-side data/structural/control hazard detector feeding the hazard-resolver FSM
//   clk, rst_n        : clock, synchronous active-low reset
//   issue_*           : instruction at issue (sources, destination, class flags)
//   br_pred_taken     : predicted direction of an issuing branch
//   res_valid/taken   : branch resolution strobe and actual direction
//   stall_in/flush_in : resolver stall (holds issue) and flush (mispredict)
//   haz_*             : resolver inputs; hz_bus packs them in resolver ui_in order
//   hz_count          : saturating hazard-cycle counter, built only with HAZ_COUNT_EN defined
module hazard_detect_unit #(
  parameter int REG_W   = 5,
  parameter int MUL_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] issue_rs1,
  input  logic [REG_W-1:0] issue_rs2,
  input  logic [REG_W-1:0] issue_rd,
  input  logic             issue_wr,
  input  logic             issue_is_load,
  input  logic             issue_is_mul,
  input  logic             issue_is_br,
  input  logic             br_pred_taken,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic             stall_in,
  input  logic             flush_in,
  output logic             haz_data,
  output logic             haz_str,
  output logic             haz_ctrl,
  output logic             haz_branch,
  output logic             haz_fwrd,
  output logic             haz_crct,
  output logic [7:0]       hz_bus,
  output logic [15:0]      hz_count
);
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             wr;
    logic             ld;
  } ent_t;
  localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);
  ent_t ex_q, ex_d, mem_q, mem_d;
  logic [3:0] mul_cnt_q, mul_cnt_d;
  logic br_act_q, br_act_d, br_pred_q, br_pred_d;
  logic accept, ex_hit, mem_hit, br_res, br_load;
  function automatic logic hit(input ent_t e, input logic [REG_W-1:0] rs);
    return e.v & e.wr & (rs != '0) & (rs == e.rd);
  endfunction
  always_comb begin
    accept     = issue_valid & ~stall_in & ~flush_in;
    // flush_in already blocks acceptance, so the new EX entry is a bubble
    ex_d       = {accept, issue_rd, issue_wr, issue_is_load};
    mem_d      = ex_q;
    ex_hit     = hit(ex_q, issue_rs1) | hit(ex_q, issue_rs2);
    mem_hit    = hit(mem_q, issue_rs1) | hit(mem_q, issue_rs2);
    haz_data   = issue_valid & (ex_hit | mem_hit);
    // a load still in EX has no data yet: load-use cannot be forwarded
    haz_fwrd   = haz_data & ~(ex_hit & ex_q.ld);
    mul_cnt_d  = (accept & issue_is_mul) ? MUL_LOAD : mul_cnt_q - 4'(mul_cnt_q != 4'd0);
    haz_str    = issue_valid & issue_is_mul & (mul_cnt_q != 4'd0);
    br_res     = br_act_q & res_valid;
    // a branch behind an unresolved one is never taken into the tracker
    br_load    = accept & issue_is_br & (~br_act_q | br_res);
    br_act_d   = br_load | (br_act_q & ~br_res);
    br_pred_d  = br_load ? br_pred_taken : br_pred_q;
    haz_ctrl   = br_act_q;
    haz_branch = br_res;
    haz_crct   = ~br_res | (res_taken == br_pred_q);
    hz_bus     = {haz_data, haz_str, haz_ctrl, haz_branch, haz_fwrd, haz_crct, 2'b00};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q      <= '0;
      mem_q     <= '0;
      mul_cnt_q <= '0;
      br_act_q  <= 1'b0;
      br_pred_q <= 1'b0;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      mul_cnt_q <= mul_cnt_d;
      br_act_q  <= br_act_d;
      br_pred_q <= br_pred_d;
    end
  end
`ifdef HAZ_COUNT_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = cnt_q + 16'((haz_data | haz_str | haz_ctrl) & (cnt_q != 16'hFFFF));
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign hz_count = cnt_q;
`else
  assign hz_count = 16'h0000;
`endif
endmodule

// File: tb/tb_hazard_detect_unit.sv
// tb_hazard_detect_unit: directed-vector self-checking bench for hazard_detect_unit
module tb_hazard_detect_unit;
  logic clk = 1'b0;
  logic rst_n;
  logic issue_valid, issue_wr, issue_is_load, issue_is_mul, issue_is_br, br_pred_taken;
  logic [4:0] issue_rs1, issue_rs2, issue_rd;
  logic res_valid, res_taken, stall_in, flush_in;
  logic haz_data, haz_str, haz_ctrl, haz_branch, haz_fwrd, haz_crct;
  logic [7:0] hz_bus;
  logic [15:0] hz_count;
  int n_chk = 0;
  int n_fail = 0;
`ifdef HAZ_COUNT_EN
  localparam logic [15:0] CNT5 = 16'd5;
`else
  localparam logic [15:0] CNT5 = 16'd0;
`endif
  hazard_detect_unit #(.REG_W(5), .MUL_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_rd(issue_rd), .issue_wr(issue_wr),
    .issue_is_load(issue_is_load), .issue_is_mul(issue_is_mul), .issue_is_br(issue_is_br),
    .br_pred_taken(br_pred_taken), .res_valid(res_valid), .res_taken(res_taken),
    .stall_in(stall_in), .flush_in(flush_in), .haz_data(haz_data), .haz_str(haz_str),
    .haz_ctrl(haz_ctrl), .haz_branch(haz_branch), .haz_fwrd(haz_fwrd), .haz_crct(haz_crct),
    .hz_bus(hz_bus), .hz_count(hz_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic idle();
    {issue_valid, issue_wr, issue_is_load, issue_is_mul, issue_is_br, br_pred_taken} = '0;
    {issue_rs1, issue_rs2, issue_rd} = '0;
    {res_valid, res_taken, stall_in, flush_in} = '0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  initial begin
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    settle();
    chk("reset_bus", 16'(hz_bus), 16'h04);
    chk("reset_cnt", hz_count, 16'h0);
    // forwarding from EX, then from MEM
    issue_valid = 1; issue_rd = 3; issue_wr = 1;
    settle();
    chk("fwd_first_bus", 16'(hz_bus), 16'h04);
    step();
    issue_rd = 0; issue_wr = 0; issue_rs1 = 3;
    settle();
    chk("fwd_ex_bus", 16'(hz_bus), 16'h8C);
    chk("fwd_ex_fwrd", 16'(haz_fwrd), 16'h1);
    issue_rs1 = 0;
    settle();
    chk("fwd_rs0_data", 16'(haz_data), 16'h0);
    step();
    issue_rs2 = 3;
    settle();
    chk("fwd_mem_bus", 16'(hz_bus), 16'h8C);
    idle(); step(); step();
    // load-use, then stall one cycle so the load reaches MEM
    issue_valid = 1; issue_rd = 5; issue_wr = 1; issue_is_load = 1;
    step();
    issue_rd = 0; issue_wr = 0; issue_is_load = 0; issue_rs2 = 5;
    settle();
    chk("lu_data", 16'(haz_data), 16'h1);
    chk("lu_fwrd", 16'(haz_fwrd), 16'h0);
    stall_in = 1;
    step();
    stall_in = 0;
    settle();
    chk("lu_mem_bus", 16'(hz_bus), 16'h8C);
    idle(); step(); step();
    // multiplier occupancy: 3 busy cycles after acceptance
    issue_valid = 1; issue_is_mul = 1;
    settle();
    chk("mul_first_str", 16'(haz_str), 16'h0);
    step();
    stall_in = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("mul_busy%0d", i), 16'(haz_str), 16'h1);
      step();
    end
    chk("mul_free_str", 16'(haz_str), 16'h0);
    idle(); step();
    // stray resolution with no branch in flight is ignored
    res_valid = 1;
    settle();
    chk("res_idle_bus", 16'(hz_bus), 16'h04);
    idle();
    // branch predicted taken, resolves taken
    issue_valid = 1; issue_is_br = 1; br_pred_taken = 1;
    settle();
    chk("br_issue_ctrl", 16'(haz_ctrl), 16'h0);
    step();
    idle();
    settle();
    chk("br_wait_bus", 16'(hz_bus), 16'h24);
    step();
    res_valid = 1; res_taken = 1;
    settle();
    chk("br_ok_bus", 16'(hz_bus), 16'h34);
    step();
    idle();
    settle();
    chk("br_done_bus", 16'(hz_bus), 16'h04);
    // mispredict, then flush kills the instruction issued alongside it
    issue_valid = 1; issue_is_br = 1;
    step();
    idle();
    step();
    res_valid = 1; res_taken = 1;
    settle();
    chk("br_bad_bus", 16'(hz_bus), 16'h30);
    step();
    idle();
    flush_in = 1; issue_valid = 1; issue_rd = 9; issue_wr = 1;
    settle();
    chk("flush_bus", 16'(hz_bus), 16'h04);
    step();
    idle();
    issue_valid = 1; issue_rs1 = 9;
    settle();
    chk("flush_kill_data", 16'(haz_data), 16'h0);
    idle(); step(); step();
    // new branch accepted in the resolve cycle reloads the tracker
    issue_valid = 1; issue_is_br = 1; br_pred_taken = 1;
    step();
    br_pred_taken = 0; res_valid = 1; res_taken = 1;
    settle();
    chk("reload_res_bus", 16'(hz_bus), 16'h34);
    step();
    idle();
    settle();
    chk("reload_ctrl_bus", 16'(hz_bus), 16'h24);
    res_valid = 1; res_taken = 0;
    settle();
    chk("reload_pred_bus", 16'(hz_bus), 16'h34);
    step();
    idle();
    settle();
    chk("reload_done_bus", 16'(hz_bus), 16'h04);
    // reset mid-flight: mul busy, branch active, writer in EX
    issue_valid = 1; issue_is_mul = 1;
    step();
    idle();
    issue_valid = 1; issue_is_br = 1; issue_rd = 4; issue_wr = 1;
    step();
    idle();
    rst_n = 0;
    step();
    rst_n = 1;
    issue_valid = 1; issue_is_mul = 1; issue_rs1 = 4; stall_in = 1;
    settle();
    chk("rst_mid_bus", 16'(hz_bus), 16'h04);
    chk("rst_mid_cnt", hz_count, 16'h0);
    idle();
    // five control-hazard edges for the counter
    issue_valid = 1; issue_is_br = 1; br_pred_taken = 1;
    step();
    idle();
    step(); step(); step(); step();
    res_valid = 1; res_taken = 1;
    step();
    idle();
    step();
    chk("count5", hz_count, CNT5);
    rst_n = 0;
    step();
    rst_n = 1;
    settle();
    chk("count_rst", hz_count, 16'h0);
    chk("final_bus", 16'(hz_bus), 16'h04);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_detect_unit.md
Name: hazard_detect_unit

Overview:
- Pipeline-side hazard detector that sits directly upstream of the hazard-resolver FSM (tt_um_fsm_haz).
- Compares the instruction at issue against in-flight EX/MEM writers, tracks multi-cycle multiplier occupancy, and tracks one outstanding branch.
- Produces the six resolver inputs: data, str, ctrl, branch, fwrd, crct.
- Also packs them into an 8-bit bus in the resolver's ui_in bit order.

Parameters:
- REG_W, 5, register-index width; index 0 is the hardwired zero register.
- MUL_LAT, 4, multiplier occupancy in cycles (legal range 2..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- issue_valid  in  1  instruction present at issue
- issue_rs1  in  REG_W  source register 1
- issue_rs2  in  REG_W  source register 2
- issue_rd  in  REG_W  destination register
- issue_wr  in  1  instruction writes issue_rd
- issue_is_load  in  1  instruction is a load
- issue_is_mul  in  1  instruction uses the multi-cycle multiplier
- issue_is_br  in  1  instruction is a conditional branch
- br_pred_taken  in  1  predictor direction for issue_is_br
- res_valid  in  1  branch resolved this cycle
- res_taken  in  1  actual branch direction
- stall_in  in  1  resolver stall; holds issue
- flush_in  in  1  resolver flush (mispredict)
- haz_data / haz_str / haz_ctrl / haz_branch / haz_fwrd / haz_crct  out  1 each  resolver inputs
- hz_bus  out  8  {data,str,ctrl,branch,fwrd,crct,0,0}
- hz_count  out  16  hazard-cycle counter (see Optional Feature)

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-low on rst_n: sampled only on the rising clk edge.
  - Reset clears EX/MEM trackers (valid=0), mul_cnt=0, branch tracker (br_act=0), and hz_count=0.
  - After reset all hazard outputs are 0 except haz_crct=1; hz_bus=8'h04.
  - Reset asserted mid-operation overrides every other event in that cycle.
- Acceptance: accept = issue_valid & !stall_in & !flush_in.
- Pipeline trackers (per edge):
  - MEM <= EX.
  - EX <= {accept, issue_rd, issue_wr, issue_is_load}, i.e. a bubble when not accepted.
  - flush_in additionally zeroes EX valid.
- Data hazard (combinational, gated by issue_valid):
  - A match is rsN != 0 and rsN == rd of a valid, writing EX or MEM entry.
  - haz_data = any match.
  - haz_fwrd = haz_data & no match against an EX entry with is_load=1 (load-use is never forwardable).
  - haz_fwrd = 0 when haz_data = 0.
- Structural hazard:
  - mul_cnt is a 4-bit down-counter, loaded with MUL_LAT-1 on an accepted mul; otherwise it decrements when nonzero.
  - haz_str = issue_valid & issue_is_mul & (mul_cnt != 0), combinational.
- Branch tracker:
  - An accepted branch sets br_act=1 and br_pred=br_pred_taken.
  - haz_ctrl = br_act (registered; first high the cycle after acceptance).
  - While br_act & res_valid:
    - haz_branch = 1.
    - haz_crct = (res_taken == br_pred).
    - br_act clears at the next edge.
  - Otherwise haz_branch=0 and haz_crct=1.
  - res_valid while br_act=0 is ignored.
  - A new branch accepted in the same cycle as resolution reloads the tracker, so br_act stays 1.
  - A branch issued while br_act=1 is not accepted (the resolver stalls it); the tracker never reloads mid-flight.
  - flush_in does not clear br_act.
- Latency:
  - data, str and fwrd: 0 cycles from the issue inputs.
  - ctrl: 1 cycle after acceptance.
  - branch and crct: 0 cycles from res_valid.
- hz_bus = {haz_data, haz_str, haz_ctrl, haz_branch, haz_fwrd, haz_crct, 2'b00}.

Optional Feature:
- Macro: HAZ_COUNT_EN.
- Defined:
  - hz_count increments by 1 on every clk edge where data|str|ctrl is high.
  - It saturates at 16'hFFFF and clears on reset.
- Undefined:
  - No counter logic is built.
  - hz_count is tied to 16'h0000.
  - All other behaviour is identical.

Test Plan:
- Forwarding:
  - Stimulus: accept rd=3 wr=1 non-load; next cycle issue rs1=3.
  - Required: haz_data=1, haz_fwrd=1, hz_bus=8'h8C.
  - Same with rs1=0: haz_data=0.
- Load-use:
  - Stimulus: accept load rd=5; next cycle issue rs2=5.
  - Required: haz_data=1, haz_fwrd=0.
  - Stimulus: hold stall_in=1 one cycle (the load moves to MEM).
  - Required: haz_fwrd=1.
- Structural:
  - Stimulus: MUL_LAT=4; accept a mul; issue a mul in the following 3 cycles.
  - Required: haz_str=1 for those 3 cycles, 0 in the 4th.
- Branch, correct prediction:
  - Stimulus: accept a branch with pred=1; two cycles later res_valid=1, res_taken=1.
  - Required: haz_ctrl=1 from cycle+1; haz_branch=1 and haz_crct=1 in the resolve cycle; haz_ctrl=0 the next cycle.
- Branch, mispredict:
  - Stimulus: pred=0, res_taken=1.
  - Required: hz_bus=8'h30 in the resolve cycle.
  - Stimulus: flush_in=1 the next cycle.
  - Required: EX entry killed, so a later rs matching its rd shows haz_data=0.
- Reset and counter:
  - Stimulus: mid-branch with mul_cnt>0, rst_n=0 for one edge.
  - Required: all trackers clear; hz_bus=8'h04.
  - Stimulus: with HAZ_COUNT_EN defined, 5 hazard cycles.
  - Required: hz_count=5; after reset hz_count=0.
